adpcm_main_mul_pipe: RTL and testbench

Parametrised pipelined multiplier for the ADPCM datapath. It replaces the fixed single-register signed×unsigned multiplier with a configurable block: per-operand signedness, pipeline depth of 1–4, optional rounded right shift, and saturating or truncating output narrowing. A valid bit travels with each sample, and an overflow flag is aligned with each result. It sits between the quantiser/predictor operand registers and the accumulators in `adpcm_main`.

---
 rtl/adpcm_main_mul_pipe_if.sv | 19 +
 rtl/adpcm_main_mul_pipe.sv | 166 ++++++++++++++++
 tb/tb_adpcm_main_mul_pipe.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/adpcm_main_mul_pipe_if.sv
// Operand/result bundle for adpcm_main_mul_pipe.
//   master : drives ce, din0, din1, in_vld; receives dout, out_vld, ovf
//   slave  : the multiplier side of the same bundle
interface adpcm_main_mul_pipe_if #(
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 13,
  parameter int dout_WIDTH = 45
);
  logic                  ce;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic                  in_vld;
  logic [dout_WIDTH-1:0] dout;
  logic                  out_vld;
  logic                  ovf;

  modport master (output ce, din0, din1, in_vld, input dout, out_vld, ovf);
  modport slave  (input ce, din0, din1, in_vld, output dout, out_vld, ovf);
endinterface

// File: rtl/adpcm_main_mul_pipe.sv
// Parametrised pipelined multiplier for the ADPCM datapath.
// Per-operand signedness, 1..4 ce-enabled stages, optional round-half-up
// right shift, and saturating or truncating narrowing to dout_WIDTH.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous active-high, clears every stage register
//   bus    : slave side of adpcm_main_mul_pipe_if
//            ce freezes all stages; in_vld qualifies din0/din1;
//            out_vld/ovf travel with dout
module adpcm_main_mul_pipe #(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = 2,
  parameter int din0_WIDTH  = 32,
  parameter int din1_WIDTH  = 13,
  parameter int dout_WIDTH  = 45,
  parameter int din0_SIGNED = 1,
  parameter int din1_SIGNED = 0,
  parameter int SHIFT       = 0,
  parameter int SATURATE    = 0
) (
  input logic                 clk,
  input logic                 reset,
  adpcm_main_mul_pipe_if.slave bus
);

  localparam int P  = din0_WIDTH + din1_WIDTH;
  localparam bit RS = (din0_SIGNED != 0) || (din1_SIGNED != 0);
  // Working width: room for the P+1 bit rounded value, dout, and one guard bit.
  localparam int WW = ((P + 1 > dout_WIDTH) ? P + 1 : dout_WIDTH) + 1;
  // Half an LSB of the shifted result; zero when SHIFT=0.
  localparam logic [P:0] RND = ((P + 1)'(1) << SHIFT) >> 1;

  // Operand extension to the full product width.
  logic [P-1:0] a_ext, b_ext;
  always_comb begin
    a_ext = (din0_SIGNED != 0) ? {{din1_WIDTH{bus.din0[din0_WIDTH-1]}}, bus.din0}
                               : {{din1_WIDTH{1'b0}}, bus.din0};
    b_ext = (din1_SIGNED != 0) ? {{din0_WIDTH{bus.din1[din1_WIDTH-1]}}, bus.din1}
                               : {{din0_WIDTH{1'b0}}, bus.din1};
  end

  // Optional extended-operand register (3 and 4 stages).
  logic [P-1:0] a_src, b_src;
  logic         vld_op;
  generate
    if (NUM_STAGE >= 3) begin : g_op_reg
      always_ff @(posedge clk) begin
        if (reset) begin
          a_src  <= '0;
          b_src  <= '0;
          vld_op <= 1'b0;
        end else if (bus.ce) begin
          a_src  <= a_ext;
          b_src  <= b_ext;
          vld_op <= bus.in_vld;
        end
      end
    end else begin : g_op_comb
      always_comb begin
        a_src  = a_ext;
        b_src  = b_ext;
        vld_op = bus.in_vld;
      end
    end
  endgenerate

  // Both operands are already extended, so the low P bits are the exact product.
  logic [P-1:0] prod;
  always_comb prod = a_src * b_src;

  // Optional product register (2 or more stages).
  logic [P-1:0] prod_src;
  logic         vld_prod;
  generate
    if (NUM_STAGE >= 2) begin : g_prod_reg
      always_ff @(posedge clk) begin
        if (reset) begin
          prod_src <= '0;
          vld_prod <= 1'b0;
        end else if (bus.ce) begin
          prod_src <= prod;
          vld_prod <= vld_op;
        end
      end
    end else begin : g_prod_comb
      always_comb begin
        prod_src = prod;
        vld_prod = vld_op;
      end
    end
  endgenerate

  // Rounding shift and narrowing.
  logic [P:0]            r_ext, r_sh;
  logic signed [P:0]     r_s;
  logic [WW-1:0]         v_w;
  logic                  fits;
  logic [dout_WIDTH-1:0] y;
  logic                  y_ovf;
  always_comb begin
    r_ext = {(RS ? prod_src[P-1] : 1'b0), prod_src} + RND;
    r_s   = r_ext;
    if (RS) r_sh = r_s >>> SHIFT;
    else    r_sh = r_ext >> SHIFT;
    v_w   = RS ? {{(WW-P-1){r_sh[P]}}, r_sh} : {{(WW-P-1){1'b0}}, r_sh};
    // In range iff every bit above the kept field is a copy of the extension bit.
    if (RS) fits = (&v_w[WW-1:dout_WIDTH-1]) || !(|v_w[WW-1:dout_WIDTH-1]);
    else    fits = !(|v_w[WW-1:dout_WIDTH]);
    y     = v_w[dout_WIDTH-1:0];
    y_ovf = 1'b0;
    if (!fits) begin
      y_ovf = 1'b1;
      if (SATURATE != 0) begin
        if (RS) y = v_w[WW-1] ? {1'b1, {(dout_WIDTH-1){1'b0}}}
                              : {1'b0, {(dout_WIDTH-1){1'b1}}};
        else    y = '1;
      end
    end
    if (!vld_prod) y_ovf = 1'b0;
  end

  // Output register, always present.
  logic [dout_WIDTH-1:0] dout_q;
  logic                  vld_q, ovf_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (bus.ce) begin
      dout_q <= y;
      vld_q  <= vld_prod;
      ovf_q  <= y_ovf;
    end
  end

  // Optional trailing delay register (4 stages).
  logic [dout_WIDTH-1:0] dout_f;
  logic                  vld_f, ovf_f;
  generate
    if (NUM_STAGE >= 4) begin : g_delay_reg
      always_ff @(posedge clk) begin
        if (reset) begin
          dout_f <= '0;
          vld_f  <= 1'b0;
          ovf_f  <= 1'b0;
        end else if (bus.ce) begin
          dout_f <= dout_q;
          vld_f  <= vld_q;
          ovf_f  <= ovf_q;
        end
      end
    end else begin : g_delay_comb
      always_comb begin
        dout_f = dout_q;
        vld_f  = vld_q;
        ovf_f  = ovf_q;
      end
    end
  endgenerate

  assign bus.dout    = dout_f;
  assign bus.out_vld = vld_f;
  assign bus.ovf     = ovf_f;

endmodule

// File: tb/tb_adpcm_main_mul_pipe.sv
// Self-checking bench for adpcm_main_mul_pipe: seven configurations share
// one stimulus stream; each is compared every cycle against a reference
// model built from integer arithmetic and a history of accepted samples.
module tb_adpcm_main_mul_pipe;

  localparam int N = 7;
  localparam int NS_T  [N] = '{2, 3, 1, 2, 4, 3, 2};
  localparam int S0_T  [N] = '{1, 1, 1, 1, 1, 0, 1};
  localparam int S1_T  [N] = '{0, 1, 0, 0, 0, 0, 0};
  localparam int SH_T  [N] = '{0, 0, 4, 0, 0, 3, 0};
  localparam int DW_T  [N] = '{45, 45, 16, 16, 45, 20, 16};
  localparam int SAT_T [N] = '{0, 0, 1, 0, 0, 1, 1};

  logic        clk = 1'b0;
  logic        reset, ce, in_vld;
  logic [31:0] din0;
  logic [12:0] din1;

  logic [63:0] od [N];
  logic        ov [N];
  logic        oo [N];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    adpcm_main_mul_pipe_if #(.din0_WIDTH(32), .din1_WIDTH(13), .dout_WIDTH(DW_T[g])) bus ();
    assign bus.ce     = ce;
    assign bus.din0   = din0;
    assign bus.din1   = din1;
    assign bus.in_vld = in_vld;
    adpcm_main_mul_pipe #(
      .ID(g + 1), .NUM_STAGE(NS_T[g]), .din0_WIDTH(32), .din1_WIDTH(13),
      .dout_WIDTH(DW_T[g]), .din0_SIGNED(S0_T[g]), .din1_SIGNED(S1_T[g]),
      .SHIFT(SH_T[g]), .SATURATE(SAT_T[g])
    ) u_dut (
      .clk(clk), .reset(reset), .bus(bus)
    );
    assign od[g] = 64'(bus.dout);
    assign ov[g] = bus.out_vld;
    assign oo[g] = bus.ovf;
  end

  typedef struct packed { logic [63:0] d; logic o; } res_t;
  typedef struct packed { logic v; logic [31:0] a; logic [12:0] b; } smp_t;

  smp_t hist[$];
  int   cnt = 0;   // ce=1 edges since the last reset

  // Value-level model: exact product, floor((p + half) / 2^SHIFT), range check.
  function automatic res_t model(input logic [31:0] a, input logic [12:0] b, input int i);
    longint av, bv, p, lo, hi, mask;
    bit     rs;
    res_t   r;
    av = (S0_T[i] != 0) ? longint'($signed(a)) : longint'(a);
    bv = (S1_T[i] != 0) ? longint'($signed(b)) : longint'(b);
    p  = av * bv;
    if (SH_T[i] > 0) p = (p + (longint'(1) <<< (SH_T[i] - 1))) >>> SH_T[i];
    rs   = (S0_T[i] != 0) || (S1_T[i] != 0);
    lo   = rs ? -(longint'(1) <<< (DW_T[i] - 1)) : 0;
    hi   = rs ? (longint'(1) <<< (DW_T[i] - 1)) - 1 : (longint'(1) <<< DW_T[i]) - 1;
    mask = (longint'(1) <<< DW_T[i]) - 1;
    r.o  = 1'b0;
    if (p < lo || p > hi) begin
      r.o = 1'b1;
      if (SAT_T[i] != 0) p = (p < lo) ? lo : hi;
    end
    r.d = 64'(p & mask);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    smp_t s;
    res_t m;
    for (int i = 0; i < N; i++) begin
      if (cnt < NS_T[i]) begin
        chk($sformatf("u%0d_empty_vld", i), 64'(ov[i]), 64'd0);
        chk($sformatf("u%0d_empty_ovf", i), 64'(oo[i]), 64'd0);
        if (cnt == 0) chk($sformatf("u%0d_rst_dout", i), od[i], 64'd0);
      end else begin
        s = hist[hist.size() - NS_T[i]];
        m = model(s.a, s.b, i);
        chk($sformatf("u%0d_vld", i), 64'(ov[i]), 64'(s.v));
        chk($sformatf("u%0d_ovf", i), 64'(oo[i]), s.v ? 64'(m.o) : 64'd0);
        if (s.v) chk($sformatf("u%0d_dout", i), od[i], m.d);
      end
    end
  endtask

  task automatic step(input bit r, input bit c, input bit v,
                      input logic [31:0] a, input logic [12:0] b);
    smp_t s;
    reset = r; ce = c; in_vld = v; din0 = a; din1 = b;
    @(posedge clk);
    #1;
    if (r) begin
      hist.delete();
      cnt = 0;
    end else if (c) begin
      s.v = v; s.a = a; s.b = b;
      hist.push_back(s);
      cnt++;
      if (hist.size() > 4) void'(hist.pop_front());
    end
    check_all();
  endtask

  initial begin
    logic [31:0] ra;
    logic [12:0] rb;
    logic [31:0] a_edge [4];
    logic [12:0] b_edge [4];
    a_edge = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF};
    b_edge = '{13'h0, 13'h1FFF, 13'h1000, 13'h0FFF};

    step(1, 1, 0, '0, '0);
    step(1, 0, 0, '0, '0);

    // Defaults (NUM_STAGE=2): -3 x 8191
    step(0, 1, 1, 32'hFFFF_FFFD, 13'd8191);
    step(0, 1, 0, '0, '0);
    chk("dflt_vld", 64'(ov[0]), 64'd1);
    chk("dflt_dout", od[0], 64'h1FFF_FFFF_A003);
    chk("dflt_ovf", 64'(oo[0]), 64'd0);

    // Back-to-back
    step(0, 1, 1, 32'd1, 13'd1);
    step(0, 1, 1, 32'd2, 13'd2);
    chk("b2b_1", od[0], 64'd1);
    step(0, 1, 1, 32'd3, 13'd3);
    chk("b2b_4", od[0], 64'd4);
    step(0, 1, 0, '0, '0);
    chk("b2b_9", od[0], 64'd9);
    chk("b2b_vld", 64'(ov[0]), 64'd1);

    // ce stall on the 3-stage instance
    step(0, 1, 0, '0, '0);
    step(0, 1, 0, '0, '0);
    step(0, 1, 0, '0, '0);
    step(0, 1, 1, 32'd7, 13'd5);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 1, 32'd9, 13'd9);
      chk("stall_vld", 64'(ov[1]), 64'd0);
    end
    step(0, 1, 0, '0, '0);
    chk("stall_pre_vld", 64'(ov[1]), 64'd0);
    step(0, 1, 0, '0, '0);
    chk("stall_vld_out", 64'(ov[1]), 64'd1);
    chk("stall_dout", od[1], 64'd35);

    // Rounding, SHIFT=4, 1 stage
    step(0, 1, 1, 32'd5, 13'd3);
    chk("rnd_5x3", od[2], 64'd1);
    step(0, 1, 1, 32'hFFFF_FFFB, 13'd3);
    chk("rnd_m5x3", od[2], 64'hFFFF);
    step(0, 1, 1, 32'd8, 13'd1);
    chk("rnd_8x1", od[2], 64'd1);
    step(0, 1, 1, 32'hFFFF_FFF8, 13'd1);
    chk("rnd_m8x1", od[2], 64'd0);
    chk("rnd_ovf", 64'(oo[2]), 64'd0);

    // Saturation, 16-bit output
    step(0, 1, 1, 32'h7FFF_FFFF, 13'd8191);
    step(0, 1, 1, 32'h8000_0000, 13'd1);
    chk("sat_pos", od[6], 64'h7FFF);
    chk("sat_pos_ovf", 64'(oo[6]), 64'd1);
    step(0, 1, 1, 32'd100, 13'd3);
    chk("sat_neg", od[6], 64'h8000);
    chk("sat_neg_ovf", 64'(oo[6]), 64'd1);
    step(0, 1, 0, '0, '0);
    chk("sat_300", od[6], 64'd300);
    chk("sat_300_ovf", 64'(oo[6]), 64'd0);

    // Truncation, 16-bit output
    step(0, 1, 1, 32'h0001_2345, 13'd1);
    step(0, 1, 1, 32'hFFFF_FFFF, 13'd1);
    chk("trunc_dout", od[3], 64'h2345);
    chk("trunc_ovf", 64'(oo[3]), 64'd1);
    step(0, 1, 0, '0, '0);
    chk("trunc_m1", od[3], 64'hFFFF);
    chk("trunc_m1_ovf", 64'(oo[3]), 64'd0);

    // Reset mid-flight on the 4-stage instance
    step(0, 1, 1, 32'd11, 13'd13);
    step(0, 1, 1, 32'd12, 13'd13);
    step(1, 1, 1, 32'd13, 13'd13);
    for (int k = 0; k < 6; k++) begin
      step(0, 1, 0, '0, '0);
      chk("midrst_vld", 64'(ov[4]), 64'd0);
    end
    step(0, 1, 1, 32'hFFFF_FF00, 13'd4095);
    step(0, 1, 0, '0, '0);
    step(0, 1, 0, '0, '0);
    chk("midrst_early", 64'(ov[4]), 64'd0);
    step(0, 1, 0, '0, '0);
    chk("midrst_vld_out", 64'(ov[4]), 64'd1);
    chk("midrst_dout", od[4], 64'h1FFF_FFF0_0100);

    // Reset while ce=0
    step(0, 1, 1, 32'd5, 13'd5);
    step(1, 0, 1, 32'd6, 13'd6);
    step(0, 0, 0, '0, '0);
    chk("rst_ce0_vld", 64'(ov[2]), 64'd0);
    chk("rst_ce0_dout", od[2], 64'd0);

    // Randomised traffic
    for (int n = 0; n < 800; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? a_edge[$urandom_range(0, 3)] : 32'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? b_edge[$urandom_range(0, 3)] : 13'($urandom);
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
